// File: rtl/generator_concat_if.sv
// Bundle of the generator_concat input request and registered result signals.
// slave: the generator itself; master: the index source / result consumer.
interface generator_concat_if #(
    parameter int SIZE = 8,
    parameter int K    = 2
);
    localparam int W = $clog2(SIZE);
    localparam int B = $clog2(K);

    logic                 in_valid;
    logic [W-1:0]         num_in;
    logic                 out_valid;
    logic [W*K-1:0]       num_out;
    logic [(W+B)*K-1:0]   out;

    modport slave (
        input  in_valid,
        input  num_in,
        output out_valid,
        output num_out,
        output out
    );

    modport master (
        output in_valid,
        output num_in,
        input  out_valid,
        input  num_out,
        input  out
    );
endinterface

// File: rtl/generator_concat.sv
// K consecutive indices from a base index, each tagged with its lane number, one register stage.
// Define GENCAT_SAT_EN to saturate indices at SIZE-1 instead of wrapping modulo SIZE.
module generator_concat #(
    parameter int SIZE = 8,
    parameter int K    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    generator_concat_if.slave  bus
);
    localparam int W = $clog2(SIZE);
    localparam int B = $clog2(K);

    logic [W*K-1:0]     num_nxt;
    logic [(W+B)*K-1:0] out_nxt;
    logic [W-1:0]       lane;
    logic [W+B-1:0]     sum;

    logic               valid_q;
    logic [W*K-1:0]     num_q;
    logic [(W+B)*K-1:0] out_q;

    always_comb begin
        num_nxt = '0;
        out_nxt = '0;
        lane    = '0;
        sum     = '0;
        for (int unsigned i = 0; i < K; i++) begin
            // W+B bits hold num_in + (K-1) without overflow since K <= SIZE
            sum = {{B{1'b0}}, bus.num_in} + (W+B)'(i);
`ifdef GENCAT_SAT_EN
            if (sum > (W+B)'(SIZE-1))
                lane = W'(SIZE-1);
            else
                lane = sum[W-1:0];
`else
            lane = sum[W-1:0];
`endif
            num_nxt[i*W +: W]         = lane;
            out_nxt[i*(W+B) +: (W+B)] = {B'(i), lane};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            num_q   <= '0;
            out_q   <= '0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                num_q <= num_nxt;
                out_q <= out_nxt;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.num_out   = num_q;
    assign bus.out       = out_q;
endmodule

// File: tb/tb_generator_concat.sv
// Directed bench for generator_concat (SIZE=8, K=2) with an arithmetic reference model.
module tb_generator_concat;
    localparam int SIZE = 8;
    localparam int K    = 2;
    localparam int W    = $clog2(SIZE);
    localparam int B    = $clog2(K);
    localparam int NW   = W*K;
    localparam int OW   = (W+B)*K;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic running;

    generator_concat_if #(.SIZE(SIZE), .K(K)) bus ();

    generator_concat #(.SIZE(SIZE), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on lane values, packed by shifting.
    function automatic int lane_val(int n, int i);
`ifdef GENCAT_SAT_EN
        return (n + i > SIZE - 1) ? SIZE - 1 : n + i;
`else
        return (n + i) % SIZE;
`endif
    endfunction

    function automatic logic [NW-1:0] model_num(int n);
        longint r = 0;
        for (int i = 0; i < K; i++)
            r = r + (longint'(lane_val(n, i)) << (i*W));
        return NW'(r);
    endfunction

    function automatic logic [OW-1:0] model_out(int n);
        longint r = 0;
        for (int i = 0; i < K; i++)
            r = r + ((longint'(i) * SIZE + longint'(lane_val(n, i))) << (i*(W+B)));
        return OW'(r);
    endfunction

    logic          m_valid;
    logic [NW-1:0] m_num;
    logic [OW-1:0] m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_num   = '0;
            m_out   = '0;
        end else begin
            m_valid = bus.in_valid;
            if (bus.in_valid) begin
                m_num = model_num(int'(bus.num_in));
                m_out = model_out(int'(bus.num_in));
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            check("model_valid", longint'(bus.out_valid), longint'(m_valid));
            check("model_num",   longint'(bus.num_out),   longint'(m_num));
            check("model_out",   longint'(bus.out),       longint'(m_out));
        end
    end

    task automatic drive(input logic v, input int n);
        @(negedge clk);
        bus.in_valid = v;
        bus.num_in   = W'(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        running      = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.num_in   = 3'd5;

        // Reset dominates a valid input, checked between and after edges
        #3;
        check("rst_valid_mid", longint'(bus.out_valid), 0);
        check("rst_num_mid",   longint'(bus.num_out),   0);
        check("rst_out_mid",   longint'(bus.out),       0);
        @(posedge clk);
        #1;
        check("rst_valid_edge", longint'(bus.out_valid), 0);
        check("rst_out_edge",   longint'(bus.out),       0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        running      = 1'b1;

        drive(1'b1, 5);
        check("basic_valid", longint'(bus.out_valid), 1);
        check("basic_num",   longint'(bus.num_out),   'h35);
        check("basic_out",   longint'(bus.out),       'hE5);
        drive(1'b0, 0);
        check("hold_valid", longint'(bus.out_valid), 0);
        check("hold_num",   longint'(bus.num_out),   'h35);
        check("hold_out",   longint'(bus.out),       'hE5);

        drive(1'b1, 7);
`ifdef GENCAT_SAT_EN
        check("sat_num", longint'(bus.num_out), 'h3F);
        check("sat_out", longint'(bus.out),     'hF7);
`else
        check("wrap_num", longint'(bus.num_out), 'h07);
        check("wrap_out", longint'(bus.out),     'h87);
`endif

        drive(1'b1, 0);
        check("b2b0_out",   longint'(bus.out),       'h90);
        check("b2b0_valid", longint'(bus.out_valid), 1);
        drive(1'b1, 1);
        check("b2b1_out",   longint'(bus.out),       'hA1);
        check("b2b1_valid", longint'(bus.out_valid), 1);
        drive(1'b1, 2);
        check("b2b2_out",   longint'(bus.out),       'hB2);
        check("b2b2_valid", longint'(bus.out_valid), 1);

        // Mid-stream reset between edges clears outputs immediately
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", longint'(bus.out_valid), 0);
        check("midrst_num",   longint'(bus.num_out),   0);
        check("midrst_out",   longint'(bus.out),       0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        drive(1'b1, 3);
        check("post_rst_out",   longint'(bus.out),       'hC3);
        check("post_rst_valid", longint'(bus.out_valid), 1);

        // Sweep every base index, with idle gaps, against the model
        for (int n = 0; n < SIZE; n++) begin
            drive(1'b1, n);
            if (n % 3 == 2) drive(1'b0, (n * 5) % SIZE);
        end
        drive(1'b0, 0);
        drive(1'b0, 0);

        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/generator_concat.md
# generator_concat

Combinational index generator plus lane-tagging concatenator behind one output register stage. From a base index `num_in` it produces K consecutive indices in the range 0..SIZE-1. It then prefixes each index with its lane number, giving tagged entries for downstream sort/select logic. It sits between the index-source control path and the lane-parallel compare datapath.

## Interface
Parameters:
- `SIZE`, default 8: index space. Power of two, ≥2. `W = $clog2(SIZE)`.
- `K`, default 2: lane count. Power of two, 2 ≤ K ≤ SIZE. `B = $clog2(K)`.

Ports:
- `clk`, input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `in_valid`, input, 1 bit: `num_in` is valid this cycle.
- `num_in`, input, W bits: base index.
- `out_valid`, output, 1 bit: registered outputs hold a valid result.
- `num_out`, output, W*K bits: K generated indices. Lane i is `num_out[i*W +: W]`.
- `out`, output, (W+B)*K bits: K tagged entries. Lane i is `out[i*(W+B) +: W+B]`.

## Operation
- Generator: `lane_i = (num_in + i) mod SIZE` for i = 0..K-1. This is a W-bit add with the carry discarded, so it wraps naturally.
- Concat: `tag_i = {i[B-1:0], lane_i}`. The lane number occupies the B MSBs and the index occupies the W LSBs.
- Lane 0 is in the least-significant position of both `num_out` and `out`.
- When `in_valid` = 1, the computed `num_out` and `out` are registered and `out_valid` goes to 1 on the next edge.
- When `in_valid` = 0, `num_out` and `out` hold their previous values and `out_valid` is cleared to 0.
- There is no backpressure. A new `in_valid` every cycle is accepted every cycle.
- With SIZE=8, K=2, `num_in`=5:
  - `num_out` = {3'd6, 3'd5} = 6'h35.
  - `out` = {1'b1,3'd6, 1'b0,3'd5} = 8'hE5.

## Timing
- Latency: exactly one clock from `in_valid` to `out_valid` and data.
- Reset: while `rst_n` = 0, asynchronously force `num_out` = 0, `out` = 0 and `out_valid` = 0, independent of `clk`.
- Reset mid-stream: an input accepted on the edge coincident with reset assertion is discarded.
- After `rst_n` deasserts, the first `in_valid` is accepted at the next rising edge.
- Wrap-around: at `num_in` = SIZE-1, lane 1 is 0, lane 2 is 1, and so on (without the macro).
- Outputs are glitch-free and change only on a clock edge or on reset.

## Configuration
- `GENCAT_SAT_EN` defined: the generator saturates instead of wrapping. `lane_i = min(num_in + i, SIZE-1)`, computed with a W+B-bit sum. Tags are unchanged.
- `GENCAT_SAT_EN` undefined: modulo-SIZE wrap as described in Operation.
- Latency, reset and valid behaviour are identical in both builds.

## Test plan
All scenarios use SIZE=8, K=2.
- Reset: `rst_n`=0 with `in_valid`=1 and `num_in`=5 → `num_out`=0, `out`=0, `out_valid`=0, including between clock edges.
- Basic: `num_in`=5 with `in_valid`=1 for one cycle → next edge `num_out`=6'h35, `out`=8'hE5, `out_valid`=1. One cycle later `out_valid`=0 and the data holds.
- Wrap (macro off): `num_in`=7 → `num_out`=6'h07 (lanes 7,0), `out`=8'h87.
- Saturate (`GENCAT_SAT_EN` on): `num_in`=7 → `num_out`=6'h3F, `out`=8'hF7.
- Back-to-back: `num_in`=0,1,2 on consecutive valid cycles → `out`=8'h90, 8'hA1, 8'hB2 on the three following edges, with `out_valid` held at 1.
- Reset mid-stream: assert `rst_n`=0 between edges while `out_valid`=1 → outputs clear immediately. After release, an input of 3 gives `out`=8'hC3.
